// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and the FIFO slave address map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    // Address map of the APB-to-FIFO slave (ADDR_W=1).
    localparam int APB_ADDR_WR = 0;
    localparam int APB_ADDR_RD = 1;

endpackage

// File: rtl/apb_master_fsm_if.sv
// Bundles the command stream, response stream and APB bus of the APB requester.
interface apb_master_fsm_if #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              PSELx;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wdog.sv
// ACCESS-phase wait counter for the APB requester; o_expired flags the LIMIT-th wait cycle.
module apb_wdog #(
    parameter int LIMIT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // r_cnt holds the waits already seen, so this cycle is wait number r_cnt+1.
    assign o_expired = i_en && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_master_fsm.sv
// Single-outstanding APB requester: cmd stream -> one APB transfer -> rsp stream.
// Define APB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES wait states.
module apb_master_fsm
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 1,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              PCLK,
    input logic              PRESETn,
    apb_master_fsm_if.master bus
);

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // SETUP  | PSELx=1, PENABLE=0 for exactly one cycle
    // ACCESS | PSELx=1, PENABLE=1 until PREADY (or timeout)
    // RESP   | rsp_valid held until rsp_ready

    apb_mst_state_t    r_state;
    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

`ifdef APB_TIMEOUT_EN
    logic w_wd_clear;
    logic w_wd_en;
    logic w_wd_expired;

    assign w_wd_clear = (r_state == SETUP);
    assign w_wd_en    = (r_state == ACCESS) && !bus.PREADY;

    apb_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_paddr  <= bus.cmd_addr;
                        r_pwrite <= bus.cmd_write;
                        r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing on the same cycle.
                    if (bus.PREADY) begin
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err   <= bus.PSLVERR;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (w_wd_expired) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_paddr     <= '0;
                    r_pwrite    <= 1'b0;
                    r_pwdata    <= '0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.PSELx     = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PADDR     = r_paddr;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: directed transfers with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_apb_master_fsm;
    import apb_pkg::*;

    localparam int AW = 1;
    localparam int DW = 8;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESETn;

    apb_master_fsm_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();

    apb_master_fsm #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (u_if)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transfer with an age since acceptance.
    bit            m_busy;
    bit            m_done;
    int            m_age;
    int            m_waits;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_err;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            chk("rst_psel",      32'(u_if.PSELx),     32'd0);
            chk("rst_penable",   32'(u_if.PENABLE),   32'd0);
            chk("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
            chk("rst_paddr",     32'(u_if.PADDR),     32'd0);
            chk("rst_pwrite",    32'(u_if.PWRITE),    32'd0);
            chk("rst_pwdata",    32'(u_if.PWDATA),    32'd0);
            chk("rst_rsp_rdata", 32'(u_if.rsp_rdata), 32'd0);
            chk("rst_rsp_err",   32'(u_if.rsp_err),   32'd0);
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_age   = 0;
            m_waits = 0;
            m_addr  = '0;
            m_write = 1'b0;
            m_wdata = '0;
            m_rdata = '0;
            m_err   = 1'b0;
        end else begin
            chk("m_cmd_ready", 32'(u_if.cmd_ready), 32'(!m_busy));
            chk("m_psel",      32'(u_if.PSELx),     32'(m_busy && !m_done));
            chk("m_penable",   32'(u_if.PENABLE),   32'(m_busy && !m_done && m_age >= 2));
            chk("m_rsp_valid", 32'(u_if.rsp_valid), 32'(m_done));
            chk("m_paddr",     32'(u_if.PADDR),     32'(m_addr));
            chk("m_pwrite",    32'(u_if.PWRITE),    32'(m_write));
            chk("m_pwdata",    32'(u_if.PWDATA),    32'(m_wdata));
            chk("m_rsp_rdata", 32'(u_if.rsp_rdata), 32'(m_rdata));
            chk("m_rsp_err",   32'(u_if.rsp_err),   32'(m_err));
            if (!m_busy) begin
                if (u_if.cmd_valid) begin
                    m_busy  = 1'b1;
                    m_done  = 1'b0;
                    m_age   = 1;
                    m_waits = 0;
                    m_addr  = u_if.cmd_addr;
                    m_write = u_if.cmd_write;
                    m_wdata = u_if.cmd_write ? u_if.cmd_wdata : '0;
                end
            end else if (!m_done) begin
                if (m_age < 2) begin
                    m_age++;
                end else if (u_if.PREADY) begin
                    m_done  = 1'b1;
                    m_rdata = m_write ? '0 : u_if.PRDATA;
                    m_err   = u_if.PSLVERR;
                end else begin
                    m_waits++;
`ifdef APB_TIMEOUT_EN
                    if (m_waits == TO) begin
                        m_done  = 1'b1;
                        m_rdata = '0;
                        m_err   = 1'b1;
                    end
`endif
                end
            end else if (u_if.rsp_ready) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Called at posedge+1 with the DUT idle; returns one cycle later in SETUP.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_write = wr;
        u_if.cmd_addr  = a;
        u_if.cmd_wdata = d;
        step();
        u_if.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pen;
        int k;
        PRESETn        = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_write = 1'b0;
        u_if.cmd_addr  = '0;
        u_if.cmd_wdata = '0;
        u_if.rsp_ready = 1'b1;
        u_if.PRDATA    = '0;
        u_if.PREADY    = 1'b1;
        u_if.PSLVERR   = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Zero-wait write.
        u_if.PRDATA = 8'hFF;
        step();
        @(negedge PCLK);
        chk("wr_idle_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
        step();
        issue(1'b1, AW'(APB_ADDR_WR), 8'hA5);
        @(negedge PCLK);
        chk("wr_setup_psel",    32'(u_if.PSELx),   32'd1);
        chk("wr_setup_penable", 32'(u_if.PENABLE), 32'd0);
        chk("wr_setup_pwdata",  32'(u_if.PWDATA),  32'hA5);
        chk("wr_setup_pwrite",  32'(u_if.PWRITE),  32'd1);
        chk("wr_setup_cmd_rdy", 32'(u_if.cmd_ready), 32'd0);
        step();
        @(negedge PCLK);
        chk("wr_access_penable", 32'(u_if.PENABLE), 32'd1);
        chk("wr_access_pwdata",  32'(u_if.PWDATA),  32'hA5);
        step();
        @(negedge PCLK);
        chk("wr_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
        chk("wr_rsp_err",   32'(u_if.rsp_err),   32'd0);
        chk("wr_rsp_rdata", 32'(u_if.rsp_rdata), 32'h00);
        chk("wr_rsp_psel",  32'(u_if.PSELx),     32'd0);
        step();
        @(negedge PCLK);
        chk("wr_done_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        chk("wr_done_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
        step();

        // Read with three wait states; PRDATA/PSLVERR garbage while PREADY low.
        u_if.PREADY  = 1'b0;
        u_if.PSLVERR = 1'b1;
        u_if.PRDATA  = 8'hEE;
        issue(1'b0, AW'(APB_ADDR_RD), 8'h00);
        @(negedge PCLK);
        chk("rd_setup_penable", 32'(u_if.PENABLE), 32'd0);
        pen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin
                u_if.PREADY  = 1'b1;
                u_if.PRDATA  = 8'h3C;
                u_if.PSLVERR = 1'b0;
            end
            @(negedge PCLK);
            if (u_if.PENABLE) pen++;
            chk("rd_access_paddr",  32'(u_if.PADDR),  32'd1);
            chk("rd_access_pwrite", 32'(u_if.PWRITE), 32'd0);
        end
        step();
        @(negedge PCLK);
        chk("rd_penable_cycles", 32'(pen),            32'd4);
        chk("rd_rsp_valid",      32'(u_if.rsp_valid), 32'd1);
        chk("rd_rsp_rdata",      32'(u_if.rsp_rdata), 32'h3C);
        chk("rd_rsp_err",        32'(u_if.rsp_err),   32'd0);
        step();

        // Slave error against the empty FIFO.
        u_if.PREADY  = 1'b1;
        u_if.PSLVERR = 1'b1;
        u_if.PRDATA  = 8'h77;
        issue(1'b0, AW'(APB_ADDR_RD), 8'h00);
        step();
        step();
        @(negedge PCLK);
        chk("err_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
        chk("err_rsp_err",   32'(u_if.rsp_err),   32'd1);
        chk("err_rsp_rdata", 32'(u_if.rsp_rdata), 32'h77);
        step();
        u_if.PSLVERR = 1'b0;
        @(negedge PCLK);
        chk("err_done_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        step();

        // Response backpressure with a second command already waiting.
        u_if.rsp_ready = 1'b0;
        u_if.PRDATA    = 8'h99;
        issue(1'b1, AW'(APB_ADDR_WR), 8'h5A);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_write = 1'b1;
        u_if.cmd_addr  = AW'(APB_ADDR_WR);
        u_if.cmd_wdata = 8'h11;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("bp_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(u_if.rsp_rdata), 32'h00);
            chk("bp_rsp_err",   32'(u_if.rsp_err),   32'd0);
            chk("bp_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
            chk("bp_psel",      32'(u_if.PSELx),     32'd0);
            step();
        end
        u_if.rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("bp_last_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
        step();
        @(negedge PCLK);
        chk("bp_idle_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        chk("bp_idle_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
        chk("bp_idle_psel",      32'(u_if.PSELx),     32'd0);
        step();
        u_if.cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("bp_next_psel",   32'(u_if.PSELx),  32'd1);
        chk("bp_next_pwdata", 32'(u_if.PWDATA), 32'h11);
        repeat (3) step();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 1500; i++) begin
            u_if.cmd_valid = 1'($urandom_range(0, 1));
            u_if.cmd_write = 1'($urandom_range(0, 1));
            u_if.cmd_addr  = AW'($urandom);
            u_if.cmd_wdata = DW'($urandom);
            u_if.PREADY    = ($urandom_range(0, 9) < 7);
            u_if.PRDATA    = DW'($urandom);
            u_if.PSLVERR   = ($urandom_range(0, 9) < 2);
            u_if.rsp_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        u_if.cmd_valid = 1'b0;
        u_if.rsp_ready = 1'b1;
        u_if.PREADY    = 1'b1;
        u_if.PSLVERR   = 1'b0;
        repeat (8) step();

        // Asynchronous reset in the middle of ACCESS.
        u_if.PREADY = 1'b0;
        issue(1'b0, AW'(APB_ADDR_RD), 8'h00);
        step();
        step();
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_psel",      32'(u_if.PSELx),     32'd0);
        chk("arst_penable",   32'(u_if.PENABLE),   32'd0);
        chk("arst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
        step();
        step();
        PRESETn     = 1'b1;
        u_if.PREADY = 1'b1;
        @(negedge PCLK);
        chk("arst_rel_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
        chk("arst_rel_psel",      32'(u_if.PSELx),     32'd0);
        step();

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after TO wait cycles, then a normal transfer.
        u_if.PREADY = 1'b0;
        issue(1'b0, AW'(APB_ADDR_RD), 8'h00);
        pen = 0;
        k   = 0;
        do begin
            step();
            @(negedge PCLK);
            if (u_if.PENABLE) pen++;
            k++;
        end while (!u_if.rsp_valid && k < 100);
        chk("to_bounded",    32'(k < 100),        32'd1);
        chk("to_pen_cycles", 32'(pen),            32'(TO));
        chk("to_rsp_valid",  32'(u_if.rsp_valid), 32'd1);
        chk("to_rsp_err",    32'(u_if.rsp_err),   32'd1);
        chk("to_rsp_rdata",  32'(u_if.rsp_rdata), 32'h00);
        step();
        u_if.PREADY = 1'b1;
        u_if.PRDATA = 8'h42;
        issue(1'b0, AW'(APB_ADDR_RD), 8'h00);
        step();
        step();
        @(negedge PCLK);
        chk("to_next_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
        chk("to_next_rsp_err",   32'(u_if.rsp_err),   32'd0);
        chk("to_next_rsp_rdata", 32'(u_if.rsp_rdata), 32'h42);
        step();
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- APB requester that turns a valid/ready command stream into single APB transfers. It returns the read data and error status on a valid/ready response stream.
- It is the initiator counterpart to the team's APB-to-FIFO slave. With ADDR_W=1, PADDR=0 writes the slave FIFO and PADDR=1 reads it.
- It sits between a local DMA/CPU-side command queue and the APB fabric.

Parameters:
- ADDR_W, 1, width of PADDR and cmd_addr.
- DATA_W, 8, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without PREADY before abort (only used with APB_TIMEOUT_EN); legal range 2..255.

Ports:
- PCLK  in  1  APB clock
- PRESETn  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  PSLVERR (or timeout) for this transfer
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset is PRESETn, asynchronous, active-low; clock is PCLK. During reset: state=IDLE, PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- All APB outputs and rsp_* are registered. cmd_ready = (state==IDLE) is combinational.
- IDLE:
  - On cmd_valid&&cmd_ready, latch cmd_addr to PADDR and cmd_write to PWRITE.
  - PWDATA takes cmd_wdata on a write and 0 on a read.
  - Set PSELx=1 and go to SETUP.
- SETUP: exactly one cycle with PSELx=1, PENABLE=0. Then set PENABLE=1 and go to ACCESS.
- ACCESS: hold PSELx=1, PENABLE=1, PADDR, PWRITE and PWDATA stable while PREADY=0. When PREADY=1:
  - rsp_rdata <= PWRITE ? 0 : PRDATA
  - rsp_err <= PSLVERR
  - PSELx <= 0, PENABLE <= 0, rsp_valid <= 1
  - go to RESP
- PSLVERR and PRDATA are ignored whenever PREADY=0.
- RESP: hold rsp_* stable until rsp_ready=1. Then clear rsp_valid and go to IDLE.
- PADDR, PWRITE and PWDATA keep their last values between transfers.
- Latency with a zero-wait slave: accept at cycle T, PSELx at T+1, PENABLE at T+2, rsp_valid at T+3. With rsp_ready held high, throughput is one transfer per 4 cycles.
- Each wait state adds one cycle. There is no pipelining and at most one transfer is outstanding.
- Commands are never dropped; cmd_ready stays low outside IDLE.
- Reset asserted mid-transfer: APB outputs drop to reset values immediately and any pending response is discarded.
- An unknown state encoding recovers to IDLE with outputs at reset values.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On the TIMEOUT_CYCLES-th such cycle the transfer aborts: PSELx=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_valid=1, go to RESP.
  - A PREADY arriving on the abort cycle itself takes priority: normal completion.
- When undefined: there is no counter and ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_pkg holds:
  - enum apb_mst_state_t {IDLE, SETUP, ACCESS, RESP} (2-bit)
  - localparam APB_ADDR_WR=0, APB_ADDR_RD=1, the FIFO slave address map shared with the slave side
- One natural sub-module, apb_wdog: the timeout counter with clear/enable/expired ports, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write, zero-wait: cmd_write=1, addr=0, wdata=0xA5, PREADY tied 1. Expect PSELx@T+1, PENABLE@T+2, PWDATA=0xA5 stable; rsp_valid@T+3 with rsp_err=0, rsp_rdata=0x00.
- Read with 3 wait states: addr=1, PREADY low 3 cycles, then high with PRDATA=0x3C. Expect PENABLE high 4 cycles, rsp_rdata=0x3C, rsp_err=0, and PADDR/PWRITE unchanged throughout ACCESS.
- Slave error: read against the empty FIFO slave (PSLVERR=1, PREADY=1). Expect rsp_err=1 and no hang.
- Response backpressure: rsp_ready low 5 cycles after rsp_valid. Expect rsp_* held, cmd_ready=0, and no new SETUP until the cycle after the rsp_ready handshake.
- Async reset: PRESETn pulled low during ACCESS. Expect PSELx/PENABLE/rsp_valid=0 without waiting for a PCLK edge, and cmd_ready=1 once PRESETn deasserts.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0. Expect abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0, and the next command accepted normally.
